n101_tl2icb_bridge: RTL and testbench

- TileLink-UL responder that accepts A-channel requests and returns D-channel responses.
- Each accepted request is converted into exactly one ICB initiator transaction, or into an immediate error response.
- Reverse direction of the ICB-to-TileLink peripheral wrappers: it lets TileLink-side initiators reach native ICB slaves.
- Single outstanding transaction; sits between a TL-UL master and the ICB peripheral bus.

---
 rtl/n101_tl2icb_bridge_if.sv | 63 ++++++
 rtl/n101_tl2icb_bridge.sv | 180 ++++++++++++++++++
 tb/tb_n101_tl2icb_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n101_tl2icb_bridge_if.sv
// Signal bundle between a TL-UL initiator, the TL-to-ICB bridge and an ICB target.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface n101_tl2icb_bridge_if #(
    parameter int TL_AW  = 29,
    parameter int ICB_AW = 32,
    parameter int SRC_W  = 5
);
    logic              io_in_0_a_valid;
    logic              io_in_0_a_ready;
    logic [2:0]        io_in_0_a_bits_opcode;
    logic [2:0]        io_in_0_a_bits_param;
    logic [2:0]        io_in_0_a_bits_size;
    logic [SRC_W-1:0]  io_in_0_a_bits_source;
    logic [TL_AW-1:0]  io_in_0_a_bits_address;
    logic [3:0]        io_in_0_a_bits_mask;
    logic [31:0]       io_in_0_a_bits_data;

    logic              io_in_0_d_valid;
    logic              io_in_0_d_ready;
    logic [2:0]        io_in_0_d_bits_opcode;
    logic [1:0]        io_in_0_d_bits_param;
    logic [2:0]        io_in_0_d_bits_size;
    logic [SRC_W-1:0]  io_in_0_d_bits_source;
    logic              io_in_0_d_bits_sink;
    logic [1:0]        io_in_0_d_bits_addr_lo;
    logic [31:0]       io_in_0_d_bits_data;
    logic              io_in_0_d_bits_error;

    logic              o_icb_cmd_valid;
    logic              o_icb_cmd_ready;
    logic [ICB_AW-1:0] o_icb_cmd_addr;
    logic              o_icb_cmd_read;
    logic [31:0]       o_icb_cmd_wdata;
    logic [3:0]        o_icb_cmd_wmask;
    logic              o_icb_rsp_valid;
    logic              o_icb_rsp_ready;
    logic [31:0]       o_icb_rsp_rdata;
    logic              o_icb_rsp_err;

    modport slave (
        input  io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
               io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
               io_in_0_a_bits_mask, io_in_0_a_bits_data, io_in_0_d_ready,
               o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
        output io_in_0_a_ready, io_in_0_d_valid, io_in_0_d_bits_opcode,
               io_in_0_d_bits_param, io_in_0_d_bits_size, io_in_0_d_bits_source,
               io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo, io_in_0_d_bits_data,
               io_in_0_d_bits_error, o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
               o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
    );

    modport master (
        output io_in_0_a_valid, io_in_0_a_bits_opcode, io_in_0_a_bits_param,
               io_in_0_a_bits_size, io_in_0_a_bits_source, io_in_0_a_bits_address,
               io_in_0_a_bits_mask, io_in_0_a_bits_data, io_in_0_d_ready,
               o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
        input  io_in_0_a_ready, io_in_0_d_valid, io_in_0_d_bits_opcode,
               io_in_0_d_bits_param, io_in_0_d_bits_size, io_in_0_d_bits_source,
               io_in_0_d_bits_sink, io_in_0_d_bits_addr_lo, io_in_0_d_bits_data,
               io_in_0_d_bits_error, o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
               o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
    );
endinterface

// File: rtl/n101_tl2icb_bridge.sv
// TL-UL responder that turns each A request into one ICB transaction (or an immediate
// error D response) with a single transaction in flight at a time.
module n101_tl2icb_bridge #(
    parameter int TL_AW  = 29,
    parameter int ICB_AW = 32,
    parameter int SRC_W  = 5
) (
    input logic                 clock,
    input logic                 reset,
    n101_tl2icb_bridge_if.slave bus
);
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    // Captured request and response
    logic [2:0]       req_opcode;
    logic [2:0]       req_size;
    logic [SRC_W-1:0] req_source;
    logic [TL_AW-1:0] req_addr;
    logic [3:0]       req_wmask;
    logic [31:0]      req_data;
    logic [31:0]      rsp_data;
    logic             rsp_error;

    logic a_ready;
    logic cmd_valid;
    logic rsp_ready;
    logic d_valid;
    logic a_fire;
    logic rsp_fire;
    logic req_get;

    logic       a_legal;
    logic       a_aligned;
    logic [3:0] full_mask;
    logic [3:0] a_wmask;

    // Param carries no meaning for TL-UL Put/Get and is deliberately dropped.
    logic unused_param;
    assign unused_param = ^bus.io_in_0_a_bits_param;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        a_aligned = 1'b0;
        full_mask = 4'b1111;
        case (bus.io_in_0_a_bits_size)
            3'd0: begin
                a_aligned = 1'b1;
                full_mask = 4'b0001 << bus.io_in_0_a_bits_address[1:0];
            end
            3'd1: begin
                a_aligned = ~bus.io_in_0_a_bits_address[0];
                full_mask = bus.io_in_0_a_bits_address[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                a_aligned = (bus.io_in_0_a_bits_address[1:0] == 2'b00);
                full_mask = 4'b1111;
            end
            default: begin
                a_aligned = 1'b0;
                full_mask = 4'b1111;
            end
        endcase

        a_legal = a_aligned &&
                  (bus.io_in_0_a_bits_opcode == OP_PUT_FULL ||
                   bus.io_in_0_a_bits_opcode == OP_PUT_PARTIAL ||
                   bus.io_in_0_a_bits_opcode == OP_GET);

        a_wmask = (bus.io_in_0_a_bits_opcode == OP_PUT_FULL) ? full_mask
                                                              : bus.io_in_0_a_bits_mask;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_ready   = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        d_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                a_ready = 1'b1;
                if (bus.io_in_0_a_valid) begin
                    state_d = a_legal ? ST_CMD : ST_RESP;
                end
            end
            ST_CMD: begin
                cmd_valid = 1'b1;
                if (bus.o_icb_cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rsp_ready = 1'b1;
                if (bus.o_icb_rsp_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                d_valid = 1'b1;
                if (bus.io_in_0_d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign a_fire   = a_ready & bus.io_in_0_a_valid;
    assign rsp_fire = rsp_ready & bus.o_icb_rsp_valid;
    assign req_get  = (req_opcode == OP_GET);

    // An illegal request skips the ICB entirely, so its error flag is set at capture time.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_opcode <= '0;
            req_size   <= '0;
            req_source <= '0;
            req_addr   <= '0;
            req_wmask  <= '0;
            req_data   <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (a_fire) begin
                req_opcode <= bus.io_in_0_a_bits_opcode;
                req_size   <= bus.io_in_0_a_bits_size;
                req_source <= bus.io_in_0_a_bits_source;
                req_addr   <= bus.io_in_0_a_bits_address;
                req_wmask  <= a_wmask;
                req_data   <= bus.io_in_0_a_bits_data;
                rsp_data   <= '0;
                rsp_error  <= ~a_legal;
            end
            if (rsp_fire) begin
                rsp_data  <= req_get ? bus.o_icb_rsp_rdata : 32'h0;
                rsp_error <= bus.o_icb_rsp_err;
            end
        end
    end

    assign bus.io_in_0_a_ready        = a_ready;

    assign bus.o_icb_cmd_valid        = cmd_valid;
    assign bus.o_icb_cmd_addr         = ICB_AW'(req_addr);
    assign bus.o_icb_cmd_read         = req_get;
    assign bus.o_icb_cmd_wdata        = req_data;
    assign bus.o_icb_cmd_wmask        = req_wmask;
    assign bus.o_icb_rsp_ready        = rsp_ready;

    assign bus.io_in_0_d_valid        = d_valid;
    assign bus.io_in_0_d_bits_opcode  = {2'b00, req_get};
    assign bus.io_in_0_d_bits_param   = 2'b00;
    assign bus.io_in_0_d_bits_size    = req_size;
    assign bus.io_in_0_d_bits_source  = req_source;
    assign bus.io_in_0_d_bits_sink    = 1'b0;
    assign bus.io_in_0_d_bits_addr_lo = req_addr[1:0];
    assign bus.io_in_0_d_bits_data    = rsp_data;
    assign bus.io_in_0_d_bits_error   = rsp_error;
endmodule

// File: tb/tb_n101_tl2icb_bridge.sv
// Self-checking bench for n101_tl2icb_bridge: directed vector table, reset-in-WAIT
// sequence and randomized transactions against a request-level reference model.
module tb_n101_tl2icb_bridge;
    localparam int TL_AW  = 29;
    localparam int ICB_AW = 32;
    localparam int SRC_W  = 5;
    localparam int BUDGET = 200;

    typedef struct {
        logic [2:0]       opcode;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic [TL_AW-1:0] addr;
        logic [3:0]       mask;
        logic [31:0]      data;
        logic [31:0]      rdata;
        logic             err;
        int               cmd_stall;
        int               rsp_delay;
        int               d_stall;
    } req_t;

    typedef struct {
        int          cmd_cnt;
        logic        read;
        logic [3:0]  wmask;
        logic [2:0]  d_opcode;
        logic [31:0] d_data;
        logic        d_error;
        int          d_first;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    typedef struct {
        int          cmd_cnt;
        int          cmd_first;
        logic [31:0] cmd_addr;
        logic        cmd_read;
        logic [31:0] cmd_wdata;
        logic [3:0]  cmd_wmask;
        int          d_first;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [4:0]  d_source;
        logic        d_sink;
        logic [1:0]  d_addr_lo;
        logic [31:0] d_data;
        logic        d_error;
        logic        unstable_cmd;
        logic        unstable_d;
        logic        a_ready_busy;
        logic        a_ready_after;
        logic        timeout;
    } obs_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    n101_tl2icb_bridge_if #(.TL_AW(TL_AW), .ICB_AW(ICB_AW), .SRC_W(SRC_W)) bus ();

    n101_tl2icb_bridge #(.TL_AW(TL_AW), .ICB_AW(ICB_AW), .SRC_W(SRC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input int op, input int sz, input int src, input logic [28:0] addr,
                                   input logic [3:0] mask, input logic [31:0] data,
                                   input logic [31:0] rdata, input logic err,
                                   input int cs, input int rd, input int ds);
        req_t r;
        r.opcode = 3'(op);  r.size = 3'(sz);  r.source = SRC_W'(src);
        r.addr = addr;      r.mask = mask;    r.data = data;
        r.rdata = rdata;    r.err = err;
        r.cmd_stall = cs;   r.rsp_delay = rd; r.d_stall = ds;
        return r;
    endfunction

    function automatic exp_t mkexp(input int cnt, input logic rd, input logic [3:0] wm, input int dop,
                                   input logic [31:0] dd, input logic de, input int df);
        exp_t e;
        e.cmd_cnt = cnt; e.read = rd; e.wmask = wm; e.d_opcode = 3'(dop);
        e.d_data = dd;   e.d_error = de; e.d_first = df;
        return e;
    endfunction

    // Reference model: what the TL side should see for one request, from the protocol rules.
    function automatic exp_t model(input req_t r);
        exp_t e;
        int   bytes;
        int   offset;
        bit   legal;
        bit   is_get;
        bytes  = 1 << int'(r.size);
        offset = int'(r.addr % 4);
        is_get = (r.opcode == 3'd4);
        legal  = (r.opcode == 3'd0 || r.opcode == 3'd1 || is_get) && (r.size <= 3'd2) &&
                 ((r.addr % bytes) == 0);
        e.cmd_cnt  = legal ? 1 : 0;
        e.read     = is_get;
        e.wmask    = (r.opcode == 3'd0) ? 4'(((1 << bytes) - 1) << offset) : r.mask;
        e.d_opcode = is_get ? 3'd1 : 3'd0;
        e.d_data   = (legal && is_get) ? r.rdata : 32'h0;
        e.d_error  = !legal || r.err;
        e.d_first  = legal ? 3 + r.cmd_stall + r.rsp_delay : 1;
        return e;
    endfunction

    task automatic idle_inputs();
        bus.io_in_0_a_valid        = 1'b0;
        bus.io_in_0_a_bits_opcode  = '0;
        bus.io_in_0_a_bits_param   = '0;
        bus.io_in_0_a_bits_size    = '0;
        bus.io_in_0_a_bits_source  = '0;
        bus.io_in_0_a_bits_address = '0;
        bus.io_in_0_a_bits_mask    = '0;
        bus.io_in_0_a_bits_data    = '0;
        bus.io_in_0_d_ready        = 1'b0;
        bus.o_icb_cmd_ready        = 1'b0;
        bus.o_icb_rsp_valid        = 1'b0;
        bus.o_icb_rsp_rdata        = '0;
        bus.o_icb_rsp_err          = 1'b0;
    endtask

    task automatic drive_a(input req_t r);
        bus.io_in_0_a_valid        = 1'b1;
        bus.io_in_0_a_bits_opcode  = r.opcode;
        bus.io_in_0_a_bits_param   = 3'($urandom);
        bus.io_in_0_a_bits_size    = r.size;
        bus.io_in_0_a_bits_source  = r.source;
        bus.io_in_0_a_bits_address = r.addr;
        bus.io_in_0_a_bits_mask    = r.mask;
        bus.io_in_0_a_bits_data    = r.data;
    endtask

    // One full transaction; cycle 0 is the A-accept cycle. Outputs are sampled at negedges.
    task automatic run_txn(input req_t r, output obs_t o);
        int cmd_held;
        int rsp_held;
        int d_held;
        int wait_a;
        bit done;
        o = '{default: 0};
        @(negedge clock);
        drive_a(r);
        wait_a = 0;
        while (!bus.io_in_0_a_ready && wait_a < BUDGET) begin
            @(negedge clock);
            wait_a++;
        end
        if (!bus.io_in_0_a_ready) begin
            o.timeout = 1'b1;
            idle_inputs();
            return;
        end
        @(negedge clock);
        cmd_held = 0;
        rsp_held = 0;
        d_held   = 0;
        done     = 1'b0;
        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            // Junk on A while busy: must be neither accepted nor sampled.
            bus.io_in_0_a_valid        = 1'($urandom_range(0, 1));
            bus.io_in_0_a_bits_opcode  = 3'($urandom);
            bus.io_in_0_a_bits_size    = 3'($urandom);
            bus.io_in_0_a_bits_source  = SRC_W'($urandom);
            bus.io_in_0_a_bits_address = TL_AW'($urandom);
            bus.io_in_0_a_bits_mask    = 4'($urandom);
            bus.io_in_0_a_bits_data    = $urandom;
            bus.o_icb_cmd_ready = 1'b0;
            bus.o_icb_rsp_valid = 1'b0;
            bus.o_icb_rsp_rdata = $urandom;
            bus.o_icb_rsp_err   = 1'($urandom);
            bus.io_in_0_d_ready = 1'b0;
            if (bus.io_in_0_a_ready) o.a_ready_busy = 1'b1;
            if (bus.o_icb_cmd_valid) begin
                if (cmd_held == 0) begin
                    o.cmd_first = cyc;
                    o.cmd_addr  = bus.o_icb_cmd_addr;
                    o.cmd_read  = bus.o_icb_cmd_read;
                    o.cmd_wdata = bus.o_icb_cmd_wdata;
                    o.cmd_wmask = bus.o_icb_cmd_wmask;
                end else if (bus.o_icb_cmd_addr !== o.cmd_addr || bus.o_icb_cmd_read !== o.cmd_read ||
                             bus.o_icb_cmd_wdata !== o.cmd_wdata || bus.o_icb_cmd_wmask !== o.cmd_wmask) begin
                    o.unstable_cmd = 1'b1;
                end
                if (cmd_held == r.cmd_stall) begin
                    bus.o_icb_cmd_ready = 1'b1;
                    o.cmd_cnt++;
                end
                cmd_held++;
            end
            if (bus.o_icb_rsp_ready) begin
                if (rsp_held == r.rsp_delay) begin
                    bus.o_icb_rsp_valid = 1'b1;
                    bus.o_icb_rsp_rdata = r.rdata;
                    bus.o_icb_rsp_err   = r.err;
                end
                rsp_held++;
            end
            if (bus.io_in_0_d_valid) begin
                if (d_held == 0) begin
                    o.d_first   = cyc;
                    o.d_opcode  = bus.io_in_0_d_bits_opcode;
                    o.d_param   = bus.io_in_0_d_bits_param;
                    o.d_size    = bus.io_in_0_d_bits_size;
                    o.d_source  = bus.io_in_0_d_bits_source;
                    o.d_sink    = bus.io_in_0_d_bits_sink;
                    o.d_addr_lo = bus.io_in_0_d_bits_addr_lo;
                    o.d_data    = bus.io_in_0_d_bits_data;
                    o.d_error   = bus.io_in_0_d_bits_error;
                end else if (bus.io_in_0_d_bits_opcode !== o.d_opcode || bus.io_in_0_d_bits_size !== o.d_size ||
                             bus.io_in_0_d_bits_source !== o.d_source || bus.io_in_0_d_bits_addr_lo !== o.d_addr_lo ||
                             bus.io_in_0_d_bits_data !== o.d_data || bus.io_in_0_d_bits_error !== o.d_error) begin
                    o.unstable_d = 1'b1;
                end
                if (d_held == r.d_stall) begin
                    bus.io_in_0_d_ready = 1'b1;
                    bus.io_in_0_a_valid = 1'b0;
                    done = 1'b1;
                end
                d_held++;
            end
            @(negedge clock);
        end
        if (!done) o.timeout = 1'b1;
        o.a_ready_after = bus.io_in_0_a_ready;
        idle_inputs();
    endtask

    task automatic compare_txn(input string tag, input req_t r, input exp_t e, input obs_t o);
        check({tag, ".timeout"}, o.timeout, 0);
        check({tag, ".cmd_count"}, o.cmd_cnt, e.cmd_cnt);
        if (e.cmd_cnt != 0) begin
            check({tag, ".cmd_first"}, o.cmd_first, 1);
            check({tag, ".cmd_addr"}, o.cmd_addr, ICB_AW'(r.addr));
            check({tag, ".cmd_read"}, o.cmd_read, e.read);
            check({tag, ".cmd_wdata"}, o.cmd_wdata, r.data);
            check({tag, ".cmd_wmask"}, o.cmd_wmask, e.wmask);
            check({tag, ".cmd_stable"}, o.unstable_cmd, 0);
        end
        check({tag, ".d_first"}, o.d_first, e.d_first);
        check({tag, ".d_opcode"}, o.d_opcode, e.d_opcode);
        check({tag, ".d_param"}, o.d_param, 0);
        check({tag, ".d_sink"}, o.d_sink, 0);
        check({tag, ".d_size"}, o.d_size, r.size);
        check({tag, ".d_source"}, o.d_source, r.source);
        check({tag, ".d_addr_lo"}, o.d_addr_lo, r.addr % 4);
        check({tag, ".d_data"}, o.d_data, e.d_data);
        check({tag, ".d_error"}, o.d_error, e.d_error);
        check({tag, ".d_stable"}, o.unstable_d, 0);
        check({tag, ".a_ready_busy"}, o.a_ready_busy, 0);
        check({tag, ".a_ready_after"}, o.a_ready_after, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        obs_t o;
        req_t r;
        int   ops[8];

        tbl[0]  = '{mkreq(4, 2, 5, 29'h0001_0008, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0),
                    mkexp(1, 1, 4'hF, 1, 32'hDEADBEEF, 0, 3)};
        tbl[1]  = '{mkreq(0, 0, 3, 29'h13, 4'h1, 32'h0000_00AB, 32'h1234_5678, 0, 0, 0, 0),
                    mkexp(1, 0, 4'h8, 0, 32'h0, 0, 3)};
        tbl[2]  = '{mkreq(4, 2, 7, 29'h2, 4'hF, 32'h0, 32'h1111, 0, 0, 0, 0),
                    mkexp(0, 1, 4'h0, 1, 32'h0, 1, 1)};
        tbl[3]  = '{mkreq(2, 2, 1, 29'h4, 4'hF, 32'h77, 32'h0, 0, 0, 0, 0),
                    mkexp(0, 0, 4'h0, 0, 32'h0, 1, 1)};
        tbl[4]  = '{mkreq(0, 1, 12, 29'h102, 4'h0, 32'hCAFE_F00D, 32'hFFFF, 0, 5, 3, 4),
                    mkexp(1, 0, 4'hC, 0, 32'h0, 0, 11)};
        tbl[5]  = '{mkreq(1, 2, 20, 29'h20, 4'h5, 32'h0102_0304, 32'h9999, 1, 0, 0, 0),
                    mkexp(1, 0, 4'h5, 0, 32'h0, 1, 3)};
        tbl[6]  = '{mkreq(4, 2, 21, 29'h24, 4'hF, 32'h0, 32'hA5A5_A5A5, 0, 0, 0, 0),
                    mkexp(1, 1, 4'hF, 1, 32'hA5A5_A5A5, 0, 3)};
        tbl[7]  = '{mkreq(4, 3, 2, 29'h0, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0),
                    mkexp(0, 1, 4'h0, 1, 32'h0, 1, 1)};
        tbl[8]  = '{mkreq(4, 1, 3, 29'h5, 4'h3, 32'h0, 32'h0, 0, 0, 0, 0),
                    mkexp(0, 1, 4'h0, 1, 32'h0, 1, 1)};
        tbl[9]  = '{mkreq(4, 0, 31, 29'h1FFF_FFFF, 4'h8, 32'h0, 32'h55, 1, 1, 2, 1),
                    mkexp(1, 1, 4'h8, 1, 32'h55, 1, 6)};
        tbl[10] = '{mkreq(0, 2, 9, 29'h100, 4'h0, 32'h8765_4321, 32'h0, 0, 0, 0, 2),
                    mkexp(1, 0, 4'hF, 0, 32'h0, 0, 3)};
        tbl[11] = '{mkreq(5, 2, 4, 29'h40, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0),
                    mkexp(0, 0, 4'h0, 0, 32'h0, 1, 1)};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset.a_ready", bus.io_in_0_a_ready, 1);
        check("reset.cmd_valid", bus.o_icb_cmd_valid, 0);
        check("reset.rsp_ready", bus.o_icb_rsp_ready, 0);
        check("reset.d_valid", bus.io_in_0_d_valid, 0);
        check("reset.d_data", bus.io_in_0_d_bits_data, 0);
        check("reset.d_error", bus.io_in_0_d_bits_error, 0);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].r, o);
            compare_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].e, o);
        end

        // Reset while waiting on the ICB response drops the transaction.
        @(negedge clock);
        drive_a(mkreq(4, 2, 17, 29'h40, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0));
        @(negedge clock);
        idle_inputs();
        check("rst_wait.cmd_valid", bus.o_icb_cmd_valid, 1);
        bus.o_icb_cmd_ready = 1'b1;
        @(negedge clock);
        bus.o_icb_cmd_ready = 1'b0;
        check("rst_wait.in_wait", bus.o_icb_rsp_ready, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_wait.a_ready", bus.io_in_0_a_ready, 1);
        check("rst_wait.cmd_valid_low", bus.o_icb_cmd_valid, 0);
        check("rst_wait.rsp_ready", bus.o_icb_rsp_ready, 0);
        check("rst_wait.d_valid", bus.io_in_0_d_valid, 0);
        check("rst_wait.d_source", bus.io_in_0_d_bits_source, 0);
        r = mkreq(4, 2, 18, 29'h0000_0C0C, 4'hF, 32'h0, 32'h0BAD_F00D, 0, 0, 1, 0);
        run_txn(r, o);
        compare_txn("rst_fresh", r, model(r), o);

        ops = '{0, 1, 4, 4, 0, 1, 2, 7};
        for (int i = 0; i < 40; i++) begin
            r.opcode    = 3'(ops[$urandom_range(0, 7)]);
            r.size      = ($urandom_range(0, 7) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            r.source    = SRC_W'($urandom);
            r.addr      = TL_AW'($urandom);
            if ($urandom_range(0, 3) != 0) r.addr = r.addr & ~(TL_AW'((1 << int'(r.size)) - 1));
            r.mask      = 4'($urandom);
            r.data      = $urandom;
            r.rdata     = $urandom;
            r.err       = ($urandom_range(0, 4) == 0);
            r.cmd_stall = $urandom_range(0, 3);
            r.rsp_delay = $urandom_range(0, 3);
            r.d_stall   = $urandom_range(0, 3);
            run_txn(r, o);
            compare_txn($sformatf("rand%0d", i), r, model(r), o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
